// File: rtl/ram_access_ctrl.sv
// Request/response front end for one single-port RAM port: issues reads/writes and
// returns read data through a 3-entry response FIFO. Optional zero-fill: RAM_CLEAR_EN.
module ram_access_ctrl #(
  parameter int unsigned dwith = 8,
  parameter int unsigned depth = 256
) (
  input  logic             clk,
  input  logic             nrst,
  // Handshakes: a beat transfers on a rising clk edge where valid & ready are both 1;
  // valid never waits on ready, and req_ready is a function of registered state only.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [dwith-1:0] req_adr,
  input  logic [dwith-1:0] req_din,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [dwith-1:0] rsp_dout,
  output logic             busy,
  output logic             ram_ce,
  output logic             ram_we,
  output logic [dwith-1:0] ram_adr,
  output logic [dwith-1:0] ram_din,
  input  logic [dwith-1:0] ram_dout,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd2;
`ifdef RAM_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd1;
`endif

  // A sweep longer than the address space cannot be expressed on ram_adr.
  if (depth > (2 ** dwith)) begin : g_depth_exceeds_address_space
  end

  logic [1:0]       state_q, state_d;
  logic             inflight_q;
  logic [1:0]       count_q, count_d;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [dwith-1:0] fifo_q [3];
  logic             accept, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits: reads accepted but not yet consumed can never exceed the FIFO size.
  assign req_ready = (state_q == ST_RUN) && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign accept    = req_valid & req_ready;
  assign push      = inflight_q;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_dout  = fifo_q[rd_ptr_q];
  assign dbg_state = state_q;

`ifdef RAM_CLEAR_EN
  logic [dwith-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_last;

  assign clr_last  = (clr_cnt_q == dwith'(depth - 1));
  assign clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + dwith'(1) : clr_cnt_q;
  assign busy      = (state_q != ST_RUN);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) clr_cnt_q <= '0;
    else       clr_cnt_q <= clr_cnt_d;
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAM_CLEAR_EN
      ST_RST:   state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
`else
      ST_RST:   state_d = ST_RUN;
`endif
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RST;
    endcase
  end

  always_comb begin
    ram_ce  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
`ifdef RAM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_ce  = 1'b1;
      ram_we  = 1'b1;
      ram_adr = clr_cnt_q;
    end else
`endif
    if (accept) begin
      ram_ce  = 1'b1;
      ram_we  = req_we;
      ram_adr = req_adr;
      ram_din = req_din;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_RST;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= accept & ~req_we;
      count_q    <= count_d;
      // ram_dout belongs to the read issued in the previous cycle.
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM, memory/credit reference
// model, scoreboard queue of expected read data with arrival cycles.
module tb_ram_access_ctrl;
  localparam int W     = 8;
  localparam int DEPTH = 16;
`ifdef RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst;
  logic         req_valid = 1'b0, req_we = 1'b0;
  logic [W-1:0] req_adr = '0, req_din = '0;
  logic         req_ready, rsp_valid, busy, ram_ce, ram_we;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_dout, ram_adr, ram_din;
  logic [W-1:0] ram_dout = '0;
  logic [1:0]   dbg_state;

  ram_access_ctrl #(.dwith(W), .depth(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
    .busy(busy), .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr),
    .ram_din(ram_din), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Environment: single-port RAM with one cycle read latency.
  logic [W-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) ram_mem[ram_adr] <= ram_din;
      else        ram_dout <= ram_mem[ram_adr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] mem_model [256];
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           n_vec = 0, n_err = 0;
  int           cyc = 0, since_rst = 0;
  int           rsp_mode = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit running, clearing, exp_rdy, exp_vld;
    cyc++;
    if (!nrst) begin
      chk("reset_outputs",
          {req_ready, rsp_valid, rsp_dout, ram_ce, ram_we, ram_adr, ram_din, busy},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, CLR});
      exp_q.delete();
      due_q.delete();
      since_rst = 0;
      if (CLR) for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    end else begin
      running  = since_rst >= (CLR ? DEPTH + 1 : 1);
      clearing = CLR && since_rst >= 1 && since_rst <= DEPTH;
      exp_rdy  = running && (exp_q.size() < 3);
      exp_vld  = (exp_q.size() > 0) && (due_q[0] <= cyc);
      chk("busy", busy, CLR && !running);
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, exp_vld);
      if (clearing)
        chk("clear_drive", {ram_ce, ram_we, ram_adr, ram_din},
            {1'b1, 1'b1, 8'(since_rst - 1), 8'h00});
      else
        chk("ram_ce", ram_ce, req_valid && exp_rdy);
      if (req_valid && exp_rdy)
        chk("ram_req", {ram_we, ram_adr, ram_din}, {req_we, req_adr, req_din});
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("rsp_data", rsp_dout, exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) mem_model[req_adr] = req_din;
        else begin
          exp_q.push_back(mem_model[req_adr]);
          due_q.push_back(cyc + 2);
        end
      end
      since_rst++;
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit we, input logic [W-1:0] adr, input logic [W-1:0] din,
                        input int max_wait, output bit acc);
    bit ok;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_din = din;
    acc = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic req_ok(input bit we, input logic [W-1:0] adr, input logic [W-1:0] din);
    bit acc;
    do_req(we, adr, din, 200, acc);
    chk("req_accept", acc, 1);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle(3);
    nrst = 1'b1;
    idle(CLR ? DEPTH + 1 : 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    nrst = 1'b1;
    #1 nrst = 1'b0;
    idle(2);
    rsp_mode = 1;
    do_reset();

    for (int a = 0; a < 256; a++)
      req_ok(1'b1, 8'(a), (a < 8) ? 8'(a + 'h40) : 8'($urandom_range(0, 255)));

    // Write then read one address; arrival latency is checked on rsp_valid.
    req_ok(1'b1, 8'h10, 8'hA5);
    req_ok(1'b0, 8'h10, 8'h00);
    wait_drain();

    // Back-to-back reads at full rate.
    for (int a = 0; a < 8; a++) req_ok(1'b0, 8'(a), 8'h00);
    wait_drain();

    // Stalled consumer: three reads fit, further ones are held off.
    rsp_mode = 0;
    idle(2);
    for (int a = 0; a < 3; a++) req_ok(1'b0, 8'(a + 2), 8'h00);
    do_req(1'b0, 8'h05, 8'h00, 4, acc);
    chk("req_blocked_rd", acc, 0);
    do_req(1'b1, 8'h06, 8'h77, 4, acc);
    chk("req_blocked_wr", acc, 0);
    rsp_mode = 1;
    wait_drain();

    // Two queued, then reads streaming while popping (push and pop together).
    rsp_mode = 0;
    idle(2);
    req_ok(1'b0, 8'h01, 8'h00);
    req_ok(1'b0, 8'h02, 8'h00);
    idle(3);
    rsp_mode = 1;
    for (int a = 0; a < 6; a++) req_ok(1'b0, 8'(a + 3), 8'h00);
    wait_drain();

    // Reset with two responses queued and one read in flight.
    for (int a = 0; a < DEPTH; a++) req_ok(1'b1, 8'(a), 8'(a + 1));
    rsp_mode = 0;
    idle(2);
    for (int a = 0; a < 3; a++) req_ok(1'b0, 8'(a + 20), 8'h00);
    do_reset();
    idle(4);
    rsp_mode = 1;
    idle(8);
    for (int a = 0; a < DEPTH; a++) req_ok(1'b0, 8'(a), 8'h00);
    wait_drain();

    // Randomised traffic with a randomly stalling consumer.
    rsp_mode = 2;
    for (int n = 0; n < 400; n++) begin
      req_ok(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rsp_mode = 1;
    wait_drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
